// File: rtl/rvec_pkg.sv
// rvec_pkg: shared definitions for the golden-response recorder.
//   - rvec_state_e : capture FSM states
//   - CNT_W        : width of the sample counter and window length
//   - SIG_W/SIG_ROT: width and rotate amount of the running response signature
//   - sig_next()   : one signature update step (rotate left, XOR sample)
package rvec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rvec_state_e;

    localparam int CNT_W   = 16;
    localparam int SIG_W   = 16;
    localparam int SIG_ROT = 1;

    // Rotate the signature left by SIG_ROT and fold in an already-width-matched sample.
    function automatic logic [SIG_W-1:0] sig_next(input logic [SIG_W-1:0] sig,
                                                  input logic [SIG_W-1:0] smp);
        return {sig[SIG_W-1-SIG_ROT:0], sig[SIG_W-1 -: SIG_ROT]} ^ smp;
    endfunction

endpackage

// File: rtl/rvec_fifo.sv
// rvec_fifo: synchronous FIFO, DEPTH x W, for buffering captured samples.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (flushes contents)
//   flush         : synchronous flush (same effect as rst on pointers/flags)
//   push, wdata   : write request and data; ignored when full unless popping
//   pop           : read request; ignored when empty
//   rdata         : head entry, forced to zero while empty
//   empty, full   : registered occupancy flags
// A push and a pop in the same cycle on a full FIFO both take effect.
module rvec_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nxt_s;
    logic          empty_r;
    logic          full_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign do_pop_s  = pop & ~empty_r;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push_s = push & (~full_r | do_pop_s);

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + (AW+1)'(1);
            2'b01:   count_nxt_s = count_r - (AW+1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, count and registered flags.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == (AW+1)'(0));
            full_r  <= (count_nxt_s == (AW+1)'(DEPTH));
        end
    end

    // Storage array; contents need no reset because the flags gate visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Head read, held at zero while empty so the output has a defined idle value.
    always_comb begin
        if (empty_r) begin
            rdata = '0;
        end else begin
            rdata = mem_r[rd_ptr_r];
        end
    end

    assign empty = empty_r;
    assign full  = full_r;

endmodule

// File: rtl/rvec_writer.sv
// rvec_writer: golden-response recorder. Captures dut_out once per clock over a
// programmed window, delays it SAMPLE_DELAY stages, buffers it in a FIFO and
// streams it out over a valid/ready link.
// Ports:
//   clk, rst            : clock (shared with the DUT), synchronous active-high reset
//   start, num_cycles   : begin a window of num_cycles samples (accepted in IDLE only)
//   dut_out             : fault-free DUT output being recorded
//   m_data/m_valid/m_ready : output stream
//   busy                : window in progress (RUN/DRAIN, one cycle behind the state)
//   done                : one-cycle end-of-window pulse
//   overflow            : sticky, a sample was dropped on a full FIFO
//   sample_cnt          : samples captured so far (drops included)
//   signature           : running MISR of captured samples (only with RVEC_SIG_EN)
// Optional feature macro: RVEC_SIG_EN.
module rvec_writer
    import rvec_pkg::*;
#(
    parameter int OUT_W        = 2,
    parameter int SAMPLE_DELAY = 1,
    parameter int DEPTH        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_cycles,
    input  logic [OUT_W-1:0] dut_out,
    output logic [OUT_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] sample_cnt
`ifdef RVEC_SIG_EN
    ,
    output logic [SIG_W-1:0] signature
`endif
);

    rvec_state_e      state_r;
    rvec_state_e      state_nxt_s;
    logic [CNT_W-1:0] num_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             ovf_r;

    logic             accept_s;
    logic             capture_s;
    logic             last_s;
    logic             busy_nxt_s;
    logic             done_nxt_s;

    logic [OUT_W-1:0]        pipe_data_r [SAMPLE_DELAY];
    logic [SAMPLE_DELAY-1:0] pipe_vld_r;
    logic                    pipe_empty_s;

    logic             fifo_push_s;
    logic             fifo_pop_s;
    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic [OUT_W-1:0] fifo_rdata_s;
    logic             drop_s;

    assign accept_s     = start & (state_r == ST_IDLE);
    assign last_s       = capture_s & (cnt_r == (num_r - 16'd1));
    assign pipe_empty_s = (pipe_vld_r == '0);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; a zero-length window skips straight to DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (num_cycles == 16'd0) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Wait for every tagged sample to reach the host.
                if (pipe_empty_s && fifo_empty_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode; busy/done are registered one cycle later.
    always_comb begin
        capture_s  = 1'b0;
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                capture_s  = 1'b0;
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
            ST_RUN: begin
                capture_s  = 1'b1;
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b0;
            end
            ST_DRAIN: begin
                capture_s  = 1'b0;
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b0;
            end
            ST_DONE: begin
                capture_s  = 1'b0;
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b1;
            end
            default: begin
                capture_s  = 1'b0;
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    // Window length latch and capture counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_r <= 16'd0;
            cnt_r <= 16'd0;
        end else if (accept_s) begin
            num_r <= num_cycles;
            cnt_r <= 16'd0;
        end else if (capture_s) begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    // Alignment pipeline: each stage carries a sample and its valid tag.
    always_ff @(posedge clk) begin
        if (rst || accept_s) begin
            pipe_vld_r <= '0;
            for (int i = 0; i < SAMPLE_DELAY; i++) begin
                pipe_data_r[i] <= '0;
            end
        end else begin
            pipe_vld_r[0]  <= capture_s;
            pipe_data_r[0] <= dut_out;
            for (int i = 1; i < SAMPLE_DELAY; i++) begin
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
                pipe_data_r[i] <= pipe_data_r[i-1];
            end
        end
    end

    assign fifo_push_s = pipe_vld_r[SAMPLE_DELAY-1];
    assign fifo_pop_s  = ~fifo_empty_s & m_ready;
    // A full FIFO only loses the sample when the host is not draining it this cycle.
    assign drop_s      = fifo_push_s & fifo_full_s & ~fifo_pop_s;

    // Sticky drop indicator, cleared for each new window.
    always_ff @(posedge clk) begin
        if (rst || accept_s) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end
    end

    rvec_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (accept_s),
        .push  (fifo_push_s),
        .wdata (pipe_data_r[SAMPLE_DELAY-1]),
        .pop   (fifo_pop_s),
        .rdata (fifo_rdata_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

`ifdef RVEC_SIG_EN
    localparam int FOLD_N = (OUT_W + SIG_W - 1) / SIG_W;

    logic [SIG_W-1:0] sig_r;

    // Fold a sample into SIG_W bits by XOR of its SIG_W-bit slices (zero-extended).
    function automatic logic [SIG_W-1:0] fold_sample(input logic [OUT_W-1:0] s);
        logic [FOLD_N*SIG_W-1:0] ext;
        logic [SIG_W-1:0]        acc;
        ext            = '0;
        ext[OUT_W-1:0] = s;
        acc            = '0;
        for (int i = 0; i < FOLD_N; i++) begin
            acc = acc ^ ext[i*SIG_W +: SIG_W];
        end
        return acc;
    endfunction

    // Signature advances at capture time, so dropped samples are still covered.
    always_ff @(posedge clk) begin
        if (rst || accept_s) begin
            sig_r <= 16'd0;
        end else if (capture_s) begin
            sig_r <= sig_next(sig_r, fold_sample(dut_out));
        end
    end

    assign signature = sig_r;
`endif

    assign m_data     = fifo_rdata_s;
    assign m_valid    = ~fifo_empty_s;
    assign busy       = busy_r;
    assign done       = done_r;
    assign overflow   = ovf_r;
    assign sample_cnt = cnt_r;

endmodule

// File: tb/tb_rvec_writer.sv
// tb_rvec_writer: directed self-checking bench for rvec_writer (DEPTH=4 build).
module tb_rvec_writer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] num_cycles;
    logic [1:0]  dut_out;
    logic [1:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] sample_cnt;
`ifdef RVEC_SIG_EN
    logic [15:0] signature;
`endif

    int chk_cnt;
    int pass_cnt;

    logic [1:0] samp [16];
    int         got [$];
    int         exp_q [$];
    int         done_cyc;
    int         done_num;
    int         busy_rise;
    int         busy_fall;
    int         busy_nd;
    int         sig_log [32];

    rvec_writer #(
        .OUT_W        (2),
        .SAMPLE_DELAY (1),
        .DEPTH        (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_cycles (num_cycles),
        .dut_out    (dut_out),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .sample_cnt (sample_cnt)
`ifdef RVEC_SIG_EN
        ,
        .signature  (signature)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare the collected output stream against exp_q.
    task automatic check_stream(input string tag);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check({tag, "_data"}, got[i], exp_q[i]);
        end
    endtask

    // Run one window of n samples from samp[]; mode 0: ready=1,
    // mode 1: ready toggles 1,0,..., mode 2: ready=0 for the first 8 cycles.
    task automatic run_window(input int n, input int mode, input int lim);
        logic       prev_hold;
        logic [1:0] prev_d;
        got.delete();
        done_cyc  = -1;
        done_num  = 0;
        busy_rise = -1;
        busy_fall = -1;
        busy_nd   = 0;
        prev_hold = 1'b0;
        prev_d    = 2'd0;
        num_cycles = 16'(n);
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= lim; c++) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (c % 2 == 1);
                default: m_ready = (c > 8);
            endcase
            if (prev_hold) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_d);
            end
            if (m_valid && m_ready) begin
                got.push_back(int'(m_data));
            end
            prev_hold = m_valid && !m_ready;
            prev_d    = m_data;
            dut_out   = (c <= n && c <= 16) ? samp[c-1] : 2'd0;
            tick();
            if (done) begin
                done_num++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (busy && busy_rise < 0) busy_rise = c;
            if (!busy && busy_rise >= 0 && busy_fall < 0) busy_fall = c;
            if (busy && !done) busy_nd++;
`ifdef RVEC_SIG_EN
            sig_log[c] = int'(signature);
`endif
        end
        m_ready = 1'b0;
    endtask

    initial begin
        chk_cnt    = 0;
        pass_cnt   = 0;
        rst        = 1'b1;
        start      = 1'b0;
        num_cycles = 16'd0;
        dut_out    = 2'd0;
        m_ready    = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_sample_cnt", sample_cnt, 0);
`ifdef RVEC_SIG_EN
        check("rst_signature", signature, 0);
`endif

        // Basic window: 4 samples, host always ready
        samp[0] = 2'd0; samp[1] = 2'd1; samp[2] = 2'd2; samp[3] = 2'd3;
        run_window(4, 0, 12);
        exp_q = '{0, 1, 2, 3};
        check_stream("basic");
        check("basic_done_cyc", done_cyc, 8);
        check("basic_done_num", done_num, 1);
        check("basic_busy_rise", busy_rise, 1);
        check("basic_busy_fall", busy_fall, 8);
        check("basic_overflow", overflow, 0);
        check("basic_sample_cnt", sample_cnt, 4);

        // Zero-length window
        run_window(0, 0, 6);
        check("zero_count", got.size(), 0);
        check("zero_done_cyc", done_cyc, 1);
        check("zero_done_num", done_num, 1);
        check("zero_busy", busy_nd, 0);
        check("zero_sample_cnt", sample_cnt, 0);

        // Overflow: 6 samples into 4 entries with host stalled
        samp[0] = 2'd3; samp[1] = 2'd1; samp[2] = 2'd2;
        samp[3] = 2'd0; samp[4] = 2'd3; samp[5] = 2'd3;
        run_window(6, 2, 18);
        exp_q = '{3, 1, 2, 0};
        check_stream("ovf");
        check("ovf_overflow", overflow, 1);
        check("ovf_sample_cnt", sample_cnt, 6);
        check("ovf_done_cyc", done_cyc, 14);
        check("ovf_done_num", done_num, 1);

        // Back-pressure with toggling ready
        samp[0] = 2'd2; samp[1] = 2'd3; samp[2] = 2'd1; samp[3] = 2'd0; samp[4] = 2'd2;
        run_window(5, 1, 16);
        exp_q = '{2, 3, 1, 0, 2};
        check_stream("bp");
        check("bp_overflow", overflow, 0);
        check("bp_sample_cnt", sample_cnt, 5);
        check("bp_done_cyc", done_cyc, 13);

        // Reset in the third RUN cycle
        samp[0] = 2'd1; samp[1] = 2'd2; samp[2] = 2'd3;
        num_cycles = 16'd10;
        m_ready    = 1'b0;
        start      = 1'b1;
        tick();
        start   = 1'b0;
        dut_out = samp[0];
        tick();
        dut_out = samp[1];
        tick();
        check("pre_rst_m_valid", m_valid, 1);
        dut_out = samp[2];
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sample_cnt", sample_cnt, 0);
        check("mid_rst_done", done, 0);
        samp[0] = 2'd2; samp[1] = 2'd0; samp[2] = 2'd1; samp[3] = 2'd3;
        run_window(4, 0, 12);
        exp_q = '{2, 0, 1, 3};
        check_stream("after_rst");
        check("after_rst_done_cyc", done_cyc, 8);
        check("after_rst_sample_cnt", sample_cnt, 4);

`ifdef RVEC_SIG_EN
        // Signature over samples 1,0,3
        samp[0] = 2'd1; samp[1] = 2'd0; samp[2] = 2'd3;
        run_window(3, 0, 10);
        check("sig_1", sig_log[1], 32'h0001);
        check("sig_2", sig_log[2], 32'h0002);
        check("sig_3", sig_log[3], 32'h0007);
        check("sig_hold", sig_log[10], 32'h0007);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/rvec_writer.md
# rvec_writer

Golden-response recorder for the fault-injection flow. It captures the output of the fault-free DUT once per clock over a programmed window, buffers the samples, and streams them to the host over a valid/ready link so they can be stored as the `.rvec` golden file. The faulty-run comparator later reads that file back. The block sits beside the DUT in the emulation wrapper and is driven by the same clock as the DUT.

## Interface
Parameters:
- `OUT_W`, 2: width of the sampled DUT output vector.
- `SAMPLE_DELAY`, 1: register stages between `dut_out` and the FIFO write. Legal range 1..4. Aligns capture with DUT settling, one full clock after the stimulus edge.
- `DEPTH`, 16: FIFO entries. Must be a power of two, at least 2.

Ports (clock and reset first):
- `clk`  in  1  single clock. Also clocks the DUT.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a capture window.
- `num_cycles`  in  16  number of samples to capture. Latched when `start` is accepted.
- `dut_out`  in  `OUT_W`  fault-free DUT output.
- `m_data`  out  `OUT_W`  sample at the FIFO head.
- `m_valid`  out  1  `m_data` is valid.
- `m_ready`  in  1  host accepts `m_data`.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse at the end of the window.
- `overflow`  out  1  sticky: at least one sample was dropped because the FIFO was full.
- `sample_cnt`  out  16  number of samples captured so far (dropped samples included).

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - `start`=1 latches `num_cycles`, clears `sample_cnt`, `overflow` and the FIFO, then goes to RUN.
  - If the latched `num_cycles`=0, go to DONE instead.
- **RUN**
  - Every cycle, `dut_out` enters the delay pipeline with a valid tag, and `sample_cnt` increments.
  - When `sample_cnt` reaches `num_cycles`−1 on the current capture, go to DRAIN next cycle.
- **DRAIN**
  - No new captures.
  - Stay until the pipeline holds no valid tags and the FIFO is empty. Then go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then IDLE.
- A tagged sample leaving the pipeline is written to the FIFO.
  - If the FIFO is full and not being popped in the same cycle, the sample is discarded and `overflow` is set.
  - `sample_cnt` is unaffected by drops.
- Output handshake:
  - A pop occurs when `m_valid & m_ready`.
  - `m_data`/`m_valid` hold stable while `m_valid & !m_ready`.
- Full FIFO with push and pop in the same cycle: both happen, no drop.
- `start` while `busy` or in DONE: ignored.
- `sample_cnt` does not wrap, because `num_cycles` is at most 65535.
- `rst` at any time: FSM to IDLE and the FIFO is flushed. Outputs take their reset values the next cycle; nothing in flight survives.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `busy`=0, `done`=0, `overflow`=0, `sample_cnt`=0, `signature`=0.
- `start` is sampled at edge E0. RUN is active from E0+1, and the first capture is `dut_out` at edge E0+1.
- Capture k is written to the FIFO at edge E0+1+k+`SAMPLE_DELAY`. It is visible on `m_data` with `m_valid`=1 in the cycle after that.
- With `m_ready` held at 1, `done` is asserted at E0+`num_cycles`+`SAMPLE_DELAY`+3.
- `busy` rises the cycle after `start` is accepted and falls in the cycle where `done`=1.

## Configuration
- Macro: `RVEC_SIG_EN`.
- **Defined:**
  - Adds output port `signature` (out, 16 bits), holding a running MISR over every captured sample, dropped samples included.
  - Update rule: `signature` ← `{signature[14:0], signature[15]}` XOR zero-extended sample. For `OUT_W`>16, the sample is first folded by XOR of its 16-bit slices.
  - Updated at capture time (pipeline input).
  - Cleared on accepted `start` and on `rst`.
  - Stable from DONE until the next `start`.
- **Not defined:** the port and its logic are absent.

## Structure
- Shared package `rvec_pkg` holds:
  - the FSM state enum;
  - the 16-bit counter width constant;
  - the signature width and polynomial-free rotate constant.
- One sub-module `rvec_fifo`: synchronous FIFO, `DEPTH` × `OUT_W`, with full/empty flags and same-cycle push/pop when full.
- The FSM, delay pipeline and signature live in the top level.

## Test plan
- `OUT_W`=2, `num_cycles`=4, `dut_out` = 0,1,2,3 on successive edges from E0+1, `m_ready`=1 → `m_data` = 0,1,2,3 in order; `done` at E0+8; `overflow`=0; `sample_cnt`=4.
- `num_cycles`=0 → no `m_valid`; `done` 2 cycles after `start`; `busy` stays 0 except in the DONE cycle.
- `DEPTH`=4, `num_cycles`=6, `m_ready`=0 until DRAIN → first 4 samples are delivered in order, the last 2 are dropped, `overflow`=1, `done` only after all 4 are popped.
- Back-pressure with `m_ready` toggling 1,0,1,0 → no sample is duplicated or lost; `m_data` stays stable while stalled.
- `rst` asserted in the 3rd RUN cycle → next cycle `m_valid`=0, `busy`=0, `sample_cnt`=0; a following `start` runs normally.
- With `RVEC_SIG_EN`, samples 1,0,3 → `signature` = 0x0001, 0x0002, 0x0007.
